// File: rtl/arbiter_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the 2-bit arbiter state encoding and the port-index constants that
// identify which requester (instruction or data cache) owns the memory.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/arbiter_pick.sv
// Combinational winner selection for the memory arbiter.
// Ports:
//   inst_req      instruction port has a pending request
//   data_req      data port has a pending request
//   starve_count  consecutive data grants taken while the instruction port waited
//   grant_valid   at least one request is pending
//   grant_port    winning port (PORT_INST or PORT_DATA), meaningful when grant_valid
module arbiter_pick
  import arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CW           = 3
) (
  input  logic          inst_req,
  input  logic          data_req,
  input  logic [CW-1:0] starve_count,
  output logic          grant_valid,
  output logic          grant_port
);

  // Data port wins by default; a starved instruction port overrides it.
  always_comb begin
    grant_valid = inst_req | data_req;
    if (inst_req && (starve_count == CW'(STARVE_LIMIT))) begin
      grant_port = PORT_INST;
    end else if (data_req) begin
      grant_port = PORT_DATA;
    end else begin
      grant_port = PORT_INST;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one memory between an instruction cache and a
// data cache.
// Ports:
//   clk, reset                          rising-edge clock, async active-high reset
//   instAddress/instReadEnable          instruction-cache request
//   instDataIn/instReady                read data and done pulse to the instruction cache
//   dataAddress/dataDataOut             data-cache address and write data
//   dataReadEnable/dataWriteEnable      data-cache request
//   dataDataIn/dataReady                read data and done pulse to the data cache
//   memoryAddress/memoryDataOut         shared memory address and write data
//   memoryReadEnable/memoryWriteEnable  shared memory strobes
//   memoryDataIn/memoryReady            shared memory read data and completion pulse
module memory_arbiter
  import arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instAddress,
  input  logic        instReadEnable,
  output logic [31:0] instDataIn,
  output logic        instReady,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataDataOut,
  input  logic        dataReadEnable,
  input  logic        dataWriteEnable,
  output logic [31:0] dataDataIn,
  output logic        dataReady,
  output logic [31:0] memoryAddress,
  output logic [31:0] memoryDataOut,
  output logic        memoryReadEnable,
  output logic        memoryWriteEnable,
  input  logic [31:0] memoryDataIn,
  input  logic        memoryReady
);

  // Wide enough to hold STARVE_LIMIT, never zero bits.
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  state_t        state;
  logic [CW-1:0] starve_count;
  logic          armed;
  logic          inst_req;
  logic          data_req;
  logic          grant_valid;
  logic          grant_port;

  assign inst_req = instReadEnable;
  assign data_req = dataReadEnable | dataWriteEnable;

  arbiter_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CW          (CW)
  ) u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .starve_count(starve_count),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Arbiter state, starvation counter and post-reset arming flag.
  // 'armed' holds off arbitration for the first edge after reset so the
  // earliest grant lands on the second rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      starve_count <= '0;
      armed        <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && grant_valid) begin
            if (grant_port == PORT_INST) begin
              state        <= GRANT_INST;
              starve_count <= '0;
            end else begin
              state <= GRANT_DATA;
              if (inst_req && (starve_count != CW'(STARVE_LIMIT))) begin
                starve_count <= starve_count + CW'(1);
              end
            end
          end
        end
        // Leave on completion, or on abandon when the port drops its enables.
        GRANT_INST: if (!inst_req || memoryReady) state <= RELEASE;
        GRANT_DATA: if (!data_req || memoryReady) state <= RELEASE;
        RELEASE:    state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Memory-side mux and port ready pulses, driven only while granted.
  // Ready is gated by the port's enables so an abandoning cycle never pulses.
  always_comb begin
    memoryAddress     = 32'd0;
    memoryDataOut     = 32'd0;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b0;
    instReady         = 1'b0;
    dataReady         = 1'b0;
    case (state)
      GRANT_INST: begin
        memoryAddress    = instAddress;
        memoryReadEnable = instReadEnable;
        instReady        = memoryReady & inst_req;
      end
      GRANT_DATA: begin
        memoryAddress     = dataAddress;
        memoryDataOut     = dataDataOut;
        memoryReadEnable  = dataReadEnable;
        memoryWriteEnable = dataWriteEnable & ~dataReadEnable;
        dataReady         = memoryReady & data_req;
      end
      default: begin
        memoryAddress = 32'd0;
      end
    endcase
  end

  assign instDataIn = memoryDataIn;
  assign dataDataIn = memoryDataIn;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum consecutive data-port grants while the instruction port waits.
REQ-002 Clock and reset are decided: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 instAddress  input  32  instruction-cache memory address.
REQ-006 instReadEnable  input  1  instruction-cache read request.
REQ-007 instDataIn  output  32  read data to the instruction cache.
REQ-008 instReady  output  1  instruction transaction done.
REQ-009 dataAddress  input  32  data-cache memory address.
REQ-010 dataDataOut  input  32  data-cache write data.
REQ-011 dataReadEnable  input  1  data-cache read request.
REQ-012 dataWriteEnable  input  1  data-cache write request.
REQ-013 dataDataIn  output  32  read data to the data cache.
REQ-014 dataReady  output  1  data transaction done.
REQ-015 memoryAddress  output  32  shared memory address.
REQ-016 memoryDataOut  output  32  shared memory write data.
REQ-017 memoryReadEnable  output  1  shared memory read strobe.
REQ-018 memoryWriteEnable  output  1  shared memory write strobe.
REQ-019 memoryDataIn  input  32  shared memory read data.
REQ-020 memoryReady  input  1  memory completion pulse.

Function
REQ-021 States SHALL be: IDLE, GRANT_INST, GRANT_DATA and RELEASE.
REQ-022 IDLE picks a winner from pending requests at the clock edge; the grant state begins on the next cycle (one-cycle arbitration latency).
REQ-023 An instruction request is instReadEnable; a data request is dataReadEnable | dataWriteEnable.
REQ-024 Priority is data-first, except when starveCount == STARVE_LIMIT and an instruction request is pending; then the instruction port wins.
REQ-025 starveCount increments on each data grant taken while an instruction request is pending, saturating at STARVE_LIMIT; it clears on any instruction grant.
REQ-026 In GRANT_x, memoryAddress/memoryDataOut SHALL be muxed combinationally from the granted port.
REQ-027 In GRANT_x, the memory strobes SHALL mirror the granted port's enables; dataReadEnable takes precedence and forces memoryWriteEnable low.
REQ-028 The arbiter holds GRANT_x until memoryReady = 1, then moves to RELEASE.
REQ-029 If the granted port drops all its enables before memoryReady, the arbiter goes to RELEASE (abandon); memoryReady in that cycle is ignored.
REQ-030 instReady = memoryReady & (state == GRANT_INST); dataReady = memoryReady & (state == GRANT_DATA); each is a single-cycle pulse.
REQ-031 instDataIn and dataDataIn both pass memoryDataIn through unconditionally.
REQ-032 RELEASE lasts exactly one cycle with all memory strobes low, then returns to IDLE.
REQ-033 A requester that still holds its enable after its ready (e.g. a misaligned second-word read) is treated as a new request and re-arbitrated.
REQ-034 memoryReady received in IDLE or RELEASE SHALL be ignored and produce no port ready.
REQ-035 If both ports request simultaneously, exactly one grant is issued; the loser waits with no ready.
REQ-036 memoryAddress and memoryDataOut are 0 outside the grant states.

Reset
REQ-037 Reset asserted (at any time, including mid-grant) forces: state = IDLE, starveCount = 0, all strobes and ready outputs = 0, memoryAddress = 0.
REQ-038 The first grant after reset deassertion is issued no earlier than the second rising clk edge.

Structure
REQ-039 State encodings (2-bit) and port-index constants SHALL reside in a shared package, arbiter_pkg.
REQ-040 A single combinational sub-module, arbiter_pick, computes the winner from the two requests, starveCount and STARVE_LIMIT; everything else stays flat.

Verification
REQ-041 Lone instruction read of 0x40, memoryReady 3 cycles later -> memoryReadEnable high for 3 cycles, instReady pulses once, then RELEASE for 1 cycle.
REQ-042 Simultaneous inst read 0x10 and data write 0x80 -> data served first (memoryWriteEnable, address 0x80), then instruction after RELEASE+IDLE.
REQ-043 Data port requests continuously while the instruction port waits, STARVE_LIMIT = 3 -> the 4th grant goes to instruction; starveCount returns to 0.
REQ-044 Data read 0x7 held across two transactions (0x7, then 0xB) -> two separate GRANT_DATA phases, two dataReady pulses.
REQ-045 Reset asserted in GRANT_DATA with memoryReady pending -> immediate IDLE, no dataReady, all strobes 0.
REQ-046 Granted port drops its enable before memoryReady -> RELEASE, no ready pulse; a stray memoryReady in IDLE is ignored.
